// File: rtl/even_counter_seq_ctrl.sv
// Run sequencer for the parity-step counter: accepts a mode/limit/sweep configuration
// and steps the count through the programmed sweeps. Optional freeze input under `PAUSE_EN.
module even_counter_seq_ctrl #(
   parameter int WIDTH  = 4,
   parameter int RWIDTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_mode,
   input  logic [WIDTH-1:0]  cfg_limit,
   input  logic [RWIDTH-1:0] cfg_reps,
   input  logic              abort,
`ifdef PAUSE_EN
   input  logic              pause,
`endif
   output logic [WIDTH-1:0]  count,
   output logic              count_vld,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    count_q, count_d;
   logic                count_vld_q, count_vld_d;
   logic                err_q, err_d;
   logic [RWIDTH-1:0]   reps_left_q, reps_left_d;
   logic [1:0]          mode_q, mode_d;
   logic [WIDTH-1:0]    limit_q, limit_d;

   logic                accept;
   logic                pause_w;
   logic [WIDTH:0]      next_w;

   function automatic logic [WIDTH-1:0] start_of(input logic [1:0] m);
      return (m == 2'b01) ? WIDTH'(1) : '0;
   endfunction

   function automatic logic [WIDTH:0] step_of(input logic [1:0] m);
      return (m == 2'b10) ? (WIDTH+1)'(1) : (WIDTH+1)'(2);
   endfunction

`ifdef PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   assign cfg_ready = (state_q == S_IDLE) && !reset;
   assign accept    = cfg_valid && cfg_ready;
   // One extra bit so a step past the top of the WIDTH range is seen as > limit, not a wrap.
   assign next_w    = {1'b0, count_q} + step_of(mode_q);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      count_vld_d = 1'b0;
      err_d       = err_q;
      reps_left_d = reps_left_q;
      mode_d      = mode_q;
      limit_d     = limit_q;
      case (state_q)
         S_IDLE: begin
            err_d = 1'b0;
            if (accept) begin
               if ((cfg_mode == 2'b11) || (cfg_limit < start_of(cfg_mode))) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d     = S_RUN;
                  count_d     = start_of(cfg_mode);
                  count_vld_d = 1'b1;
                  reps_left_d = cfg_reps;
                  mode_d      = cfg_mode;
                  limit_d     = cfg_limit;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (pause_w) begin
               state_d = S_RUN;
            end else if (next_w <= {1'b0, limit_q}) begin
               count_d     = next_w[WIDTH-1:0];
               count_vld_d = 1'b1;
            end else if (reps_left_q == RWIDTH'(1)) begin
               state_d = S_DONE;
            end else begin
               // A zero sweep count never decrements, giving a free run until abort.
               count_d     = start_of(mode_q);
               count_vld_d = 1'b1;
               if (reps_left_q != '0) reps_left_d = reps_left_q - RWIDTH'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         count_vld_q <= 1'b0;
         err_q       <= 1'b0;
         reps_left_q <= '0;
         mode_q      <= 2'b00;
         limit_q     <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         count_vld_q <= count_vld_d;
         err_q       <= err_d;
         reps_left_q <= reps_left_d;
         mode_q      <= mode_d;
         limit_q     <= limit_d;
      end
   end

   assign count     = count_q;
   assign count_vld = count_vld_q;
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_even_counter_seq_ctrl.sv
// Scoreboard bench for even_counter_seq_ctrl: directed runs push expected count/done
// events into a queue that a negedge monitor pops as the DUT presents them.
module tb_even_counter_seq_ctrl;

   localparam int WIDTH  = 4;
   localparam int RWIDTH = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_mode;
   logic [WIDTH-1:0]  cfg_limit;
   logic [RWIDTH-1:0] cfg_reps;
   logic              abort;
`ifdef PAUSE_EN
   logic              pause;
`endif
   logic [WIDTH-1:0]  count;
   logic              count_vld;
   logic              busy;
   logic              done;
   logic              err;

   typedef struct packed {
      logic             is_done;
      logic             err;
      logic [WIDTH-1:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   passes = 0;
   int   total  = 0;

   even_counter_seq_ctrl #(.WIDTH(WIDTH), .RWIDTH(RWIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_mode  (cfg_mode),
      .cfg_limit (cfg_limit),
      .cfg_reps  (cfg_reps),
      .abort     (abort),
`ifdef PAUSE_EN
      .pause     (pause),
`endif
      .count     (count),
      .count_vld (count_vld),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic push_cnt(input int v);
      exp_t e;
      e.is_done = 1'b0;
      e.err     = 1'b0;
      e.val     = WIDTH'(v);
      exp_q.push_back(e);
   endtask

   task automatic push_done(input logic e_err);
      exp_t e;
      e.is_done = 1'b1;
      e.err     = e_err;
      e.val     = '0;
      exp_q.push_back(e);
   endtask

   // Returns at accept-edge + 1 time unit with cfg_valid dropped.
   task automatic send_cfg(input logic [1:0] m, input int lim, input int reps);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      cfg_valid = 1'b1;
      cfg_mode  = m;
      cfg_limit = WIDTH'(lim);
      cfg_reps  = RWIDTH'(reps);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cfg_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("cfg_ready_timeout", 0, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   // Monitor: every presented count value or done pulse must match the queue head.
   always begin
      exp_t e;
      @(negedge clk);
      if (count_vld || done) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_output: count_vld=%0b count=%0d done=%0b err=%0b, expected nothing",
                     count_vld, count, done, err);
         end else begin
            e = exp_q.pop_front();
            if (e.is_done) begin
               if (done && !count_vld && (err == e.err)) passes++;
               else $display("FAIL done_event: done=%0b count_vld=%0b err=%0b, expected done=1 err=%0b",
                             done, count_vld, err, e.err);
            end else begin
               if (count_vld && !done && (count == e.val)) passes++;
               else $display("FAIL count_event: count_vld=%0b count=%0d done=%0b, expected count=%0d",
                             count_vld, count, done, e.val);
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      cfg_valid = 1'b0;
      cfg_mode  = 2'b00;
      cfg_limit = '0;
      cfg_reps  = '0;
      abort     = 1'b0;
`ifdef PAUSE_EN
      pause     = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cfg_ready", int'(cfg_ready), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_count_vld", int'(count_vld), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_cfg_ready", int'(cfg_ready), 1);

      // even, limit 9, two sweeps
      for (int r = 0; r < 2; r++)
         for (int v = 0; v <= 8; v += 2) push_cnt(v);
      push_done(1'b0);
      send_cfg(2'b00, 9, 2);
      wait_done();

      // odd, limit 7, one sweep; cfg fields change mid-run
      for (int v = 1; v <= 7; v += 2) push_cnt(v);
      push_done(1'b0);
      send_cfg(2'b01, 7, 1);
      cfg_mode  = 2'b10;
      cfg_limit = 4'd15;
      cfg_reps  = 4'd5;
      @(negedge clk);
      chk("run_busy", int'(busy), 1);
      chk("run_cfg_ready", int'(cfg_ready), 0);
      wait_done();

      // odd with limit below start: rejected
      push_done(1'b1);
      send_cfg(2'b01, 0, 1);
      wait_done();
      @(negedge clk);
      chk("err_cleared", int'(err), 0);

      // reserved mode: rejected
      push_done(1'b1);
      send_cfg(2'b11, 9, 1);
      wait_done();

      // all mode, full 4-bit range
      for (int v = 0; v <= 15; v++) push_cnt(v);
      push_done(1'b0);
      send_cfg(2'b10, 15, 1);
      wait_done();

      // even, limit 14, free-run; abort sampled after 40 values
      for (int i = 0; i < 40; i++) push_cnt((i % 8) * 2);
      send_cfg(2'b00, 14, 0);
      repeat (39) begin
         @(posedge clk); #1;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_cfg_ready", int'(cfg_ready), 1);
      chk("abort_done", int'(done), 0);
      chk("abort_count_held", int'(count), 14);
      repeat (4) @(posedge clk);

      // reset mid-run at count 6
      for (int v = 0; v <= 6; v += 2) push_cnt(v);
      send_cfg(2'b00, 14, 1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_count", int'(count), 0);
      chk("midrst_count_vld", int'(count_vld), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_cfg_ready", int'(cfg_ready), 1);
      for (int v = 0; v <= 4; v += 2) push_cnt(v);
      push_done(1'b0);
      send_cfg(2'b00, 4, 1);
      wait_done();

`ifdef PAUSE_EN
      // pause three cycles while count is 4
      for (int v = 0; v <= 8; v += 2) push_cnt(v);
      push_done(1'b0);
      send_cfg(2'b00, 8, 1);
      repeat (2) begin
         @(posedge clk); #1;
      end
      pause = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("pause_count", int'(count), 4);
         chk("pause_busy", int'(busy), 1);
      end
      pause = 1'b0;
      wait_done();
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
